// File: rtl/matmul_pkg.sv
// Shared types for the 4x4 fp16 matrix-vector controller and its result FIFO.
package matmul_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [3:0] vec4_t;
    typedef fp16_t [15:0] mat4_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP
    } ctrl_state_t;

endpackage

// File: rtl/matmul_res_fifo.sv
// Result FIFO for finished vectors; depth need not be a power of two.
module matmul_res_fifo
    import matmul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [3:0][15:0] push_data_i,
    input  logic             pop_i,
    output logic [3:0][15:0] head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    vec4_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign doPop   = pop_i && !empty_o;
    // A pop frees the slot the push lands in, so push-at-full is fine when popping.
    assign doPush  = push_i && (!full || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == LAST) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == LAST) ? '0 : rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= push_data_i;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop_i));

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for the 4x4 fp16 matrix-vector datapath: weight double-buffering,
// credit-based vector issue, in-flight tagging and result buffering.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int PIPE_LAT  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [15:0]       cfg_data,
    input  logic              cfg_commit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0][15:0]  in_data,
    output logic [15:0][15:0] mm_a,
    output logic [3:0][15:0]  mm_b,
    input  logic [3:0][15:0]  mm_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0][15:0]  out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  res_cnt
);

    localparam int FC_W = $clog2(OUT_DEPTH + 1);
    localparam int IF_W = $clog2(PIPE_LAT + 1);
    localparam logic [31:0] DEPTH_U = 32'(OUT_DEPTH);

    ctrl_state_t         state_q, state_d;
    mat4_t               shadow_q, shadow_d;
    mat4_t               active_q, active_d;
    logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
    logic [IF_W-1:0]     inFlight_q, inFlight_d;
    logic [CNT_W-1:0]    resCnt_q, resCnt_d;
    logic [FC_W-1:0]     fifoCnt;
    logic [31:0]         creditUsed;
    logic                fifoEmpty;
    logic                fire;
    logic                push;
    logic                pop;

    assign push = vpipe_q[PIPE_LAT-1];

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        resCnt_d   = resCnt_q;
        creditUsed = 32'(fifoCnt) + 32'(inFlight_q);
        // Every accepted vector reserves a FIFO slot, so results are never dropped.
        in_ready   = (state_q == RUN) && (creditUsed < DEPTH_U);
        fire       = in_valid && in_ready;
        mm_b       = fire ? in_data : '0;
        out_valid  = !fifoEmpty;
        pop        = out_valid && out_ready;
        busy       = (state_q == DRAIN) || (inFlight_q != '0);
        vpipe_d    = {vpipe_q[PIPE_LAT-2:0], fire};
        inFlight_d = inFlight_q + IF_W'(fire) - IF_W'(push);

        if (cfg_we) begin
            shadow_d[cfg_addr] = cfg_data;
        end
        if (pop) begin
            resCnt_d = resCnt_q + CNT_W'(1);
        end

        // Active weights only change once the pipe is empty, so no result mixes weight sets.
        case (state_q)
            RUN: begin
                if (cfg_commit) state_d = DRAIN;
            end
            DRAIN: begin
                if (inFlight_q == '0) state_d = SWAP;
            end
            SWAP: begin
                active_d = shadow_q;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            shadow_q   <= '0;
            active_q   <= '0;
            vpipe_q    <= '0;
            inFlight_q <= '0;
            resCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            vpipe_q    <= vpipe_d;
            inFlight_q <= inFlight_d;
            resCnt_q   <= resCnt_d;
        end
    end

    assign mm_a    = active_q;
    assign res_cnt = resCnt_q;

    matmul_res_fifo #(
        .DEPTH(OUT_DEPTH),
        .CNT_W(FC_W)
    ) u_res_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .push_data_i(mm_x),
        .pop_i      (pop),
        .head_o     (out_data),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCnt)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl; a delay-line stand-in plays the fp16 datapath
// using small integer operands so every product and sum is exact.
`timescale 1ns/1ps
module tb_matmul_ctrl;

    localparam int PIPE_LAT  = 4;
    localparam int OUT_DEPTH = 4;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [15:0]       cfg_data;
    logic              cfg_commit;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][15:0]  in_data;
    logic [15:0][15:0] mm_a;
    logic [3:0][15:0]  mm_b;
    logic [3:0][15:0]  mm_x;
    logic              out_valid;
    logic              out_ready;
    logic [3:0][15:0]  out_data;
    logic              busy;
    logic [CNT_W-1:0]  res_cnt;

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int lastFireCycle = 0;
    int issued = 0;
    int popsSeen = 0;
    int shadowModel [16];
    int activeModel [16];
    logic [3:0][15:0] expQ [$];
    logic [3:0][15:0] dpStage [PIPE_LAT];
    bit senderDone;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    matmul_ctrl #(
        .PIPE_LAT (PIPE_LAT),
        .OUT_DEPTH(OUT_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_commit(cfg_commit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_x      (mm_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .res_cnt   (res_cnt)
    );

    function automatic logic [15:0] intToFp16(input int v);
        int e;
        logic [15:0] r;
        if (v == 0) return 16'h0000;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        r[15]    = 1'b0;
        r[14:10] = 5'(e + 15);
        r[9:0]   = 10'((v << (10 - e)) & 32'h3FF);
        return r;
    endfunction

    function automatic int fp16ToInt(input logic [15:0] f);
        int e;
        int m;
        if (f[14:0] == 15'h0) return 0;
        e = int'(f[14:10]) - 15;
        m = int'(f[9:0]) | 32'h400;
        return (e >= 10) ? (m << (e - 10)) : (m >> (10 - e));
    endfunction

    function automatic logic [3:0][15:0] datapathProduct(input logic [15:0][15:0] a,
                                                         input logic [3:0][15:0] b);
        logic [3:0][15:0] res;
        for (int r = 0; r < 4; r++) begin
            int acc = 0;
            for (int c = 0; c < 4; c++) acc += fp16ToInt(a[4*r+c]) * fp16ToInt(b[c]);
            res[r] = intToFp16(acc);
        end
        return res;
    endfunction

    function automatic logic [3:0][15:0] refResult(input int v [4]);
        logic [3:0][15:0] res;
        for (int r = 0; r < 4; r++) begin
            int acc = 0;
            for (int c = 0; c < 4; c++) acc += activeModel[4*r+c] * v[c];
            res[r] = intToFp16(acc);
        end
        return res;
    endfunction

    // Datapath stand-in: registered product then a delay line, cleared with the controller reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) dpStage[i] <= '0;
        end else begin
            dpStage[0] <= datapathProduct(mm_a, mm_b);
            for (int i = 1; i < PIPE_LAT; i++) dpStage[i] <= dpStage[i-1];
        end
    end
    assign mm_x = dpStage[PIPE_LAT-1];

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // All driving tasks start and end just after a rising edge.
    task automatic applyStimulus(input int v [4]);
        bit done = 1'b0;
        logic [3:0][15:0] vec;
        for (int c = 0; c < 4; c++) vec[c] = intToFp16(v[c]);
        in_data  = vec;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back(refResult(v));
                issued++;
                lastFireCycle = cycle;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("issue_accepted", 256'(done), 256'(1));
    endtask

    task automatic writeWeight(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = intToFp16(val);
        shadowModel[addr] = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic commitWeights();
        bit done = 1'b0;
        cfg_commit = 1'b1;
        activeModel = shadowModel;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("commit_completes", 256'(done), 256'(1));
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        popsSeen = 0;
        for (int i = 0; i < 16; i++) begin
            shadowModel[i] = 0;
            activeModel[i] = 0;
        end
    endtask

    task automatic waitQueueEmpty(input string name);
        for (int t = 0; t < 400 && expQ.size() != 0; t++) @(posedge clk);
        #1;
        checkOutput(name, 256'(expQ.size()), 256'(0));
    endtask

    // Monitor: every popped result must be the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checkOutput("result_was_expected", 256'(expQ.size() != 0), 256'(1));
                if (expQ.size() != 0) checkOutput("result_data", 256'(out_data), 256'(expQ.pop_front()));
                checkOutput("res_cnt_at_pop", 256'(res_cnt), 256'(CNT_W'(popsSeen)));
                popsSeen++;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idVec [4];
        int v [4];
        int base;
        int low;
        int swapCycles;
        int stale;
        bit seen;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        resetDut();

        @(negedge clk);
        checkOutput("reset_in_ready", 256'(in_ready), 256'(1));
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_out_data", 256'(out_data), 256'(0));
        checkOutput("reset_mm_b", 256'(mm_b), 256'(0));
        checkOutput("reset_mm_a", 256'(mm_a), 256'(0));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_res_cnt", 256'(res_cnt), 256'(0));
        @(posedge clk); #1;

        // Identity weights: the vector comes back unchanged, PIPE_LAT+1 cycles after fire.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) writeWeight(i, (i % 5 == 0) ? 1 : 0);
        commitWeights();
        idVec = '{1, 2, 3, 4};
        applyStimulus(idVec);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("identity_latency", 256'(cycle - lastFireCycle), 256'(PIPE_LAT + 1));
        checkOutput("identity_data", 256'(out_data), 256'(64'h4400_4200_4000_3C00));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("identity_res_cnt", 256'(res_cnt), 256'(1));
        @(posedge clk); #1;

        // Back-pressure with all-ones weights: only OUT_DEPTH vectors get in.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) writeWeight(i, 1);
        commitWeights();
        base = issued;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    for (int c = 0; c < 4; c++) v[c] = $urandom_range(0, 15);
                    applyStimulus(v);
                end
            end
            begin
                repeat (15) @(negedge clk);
                checkOutput("bp_accepted", 256'(issued - base), 256'(OUT_DEPTH));
                checkOutput("bp_in_ready_low", 256'(in_ready), 256'(0));
                checkOutput("bp_out_valid", 256'(out_valid), 256'(1));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        waitQueueEmpty("bp_all_results");
        checkOutput("bp_total_issued", 256'(issued - base), 256'(8));

        // Commit with three vectors in flight: stall covers the drain plus a single SWAP cycle.
        for (int i = 0; i < 16; i++) writeWeight(i, (i % 5 == 0) ? 2 : 0);
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) v[c] = $urandom_range(0, 15);
            applyStimulus(v);
        end
        cfg_commit = 1'b1;
        activeModel = shadowModel;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        low = 0;
        swapCycles = 0;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
            else begin
                low++;
                if (!busy) swapCycles++;
            end
        end
        checkOutput("commit_stall_cycles", 256'(low), 256'(PIPE_LAT + 1));
        checkOutput("swap_cycle_count", 256'(swapCycles), 256'(1));
        @(posedge clk); #1;
        waitQueueEmpty("commit_old_results");
        applyStimulus(idVec);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("double_weights_data", 256'(out_data), 256'(64'h4800_4600_4400_4000));
        @(posedge clk); #1;
        waitQueueEmpty("double_weights_drain");

        // Reset with two results in flight and two parked in the FIFO.
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 4; c++) v[c] = $urandom_range(1, 15);
            applyStimulus(v);
        end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pre_reset_out_valid", 256'(out_valid), 256'(1));
        checkOutput("pre_reset_busy", 256'(busy), 256'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        popsSeen = 0;
        for (int i = 0; i < 16; i++) begin
            shadowModel[i] = 0;
            activeModel[i] = 0;
        end
        @(negedge clk);
        checkOutput("post_reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("post_reset_res_cnt", 256'(res_cnt), 256'(0));
        checkOutput("post_reset_busy", 256'(busy), 256'(0));
        checkOutput("post_reset_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("no_stale_result", 256'(stale), 256'(0));
        @(posedge clk); #1;

        // A write landing in the SWAP cycle stays in shadow until the next commit.
        writeWeight(5, 3);
        cfg_commit = 1'b1;
        activeModel = shadowModel;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_addr = 4'd5;
        cfg_data = intToFp16(7);
        shadowModel[5] = 7;
        @(negedge clk);
        checkOutput("swap_in_ready", 256'(in_ready), 256'(0));
        checkOutput("swap_busy", 256'(busy), 256'(0));
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        checkOutput("swap_write_excluded", 256'(mm_a[5]), 256'(16'h4200));
        checkOutput("swap_then_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        commitWeights();
        @(negedge clk);
        checkOutput("next_commit_applies", 256'(mm_a[5]), 256'(16'h4700));
        @(posedge clk); #1;

        // Random traffic against the reference model.
        for (int i = 0; i < 16; i++) writeWeight(i, $urandom_range(0, 3));
        commitWeights();
        base = popsSeen;
        senderDone = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    for (int c = 0; c < 4; c++) v[c] = $urandom_range(0, 15);
                    applyStimulus(v);
                end
                senderDone = 1'b1;
            end
            begin
                for (int t = 0; t < 20000 && !(senderDone && expQ.size() == 0); t++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        waitQueueEmpty("random_queue_empty");
        checkOutput("random_all_popped", 256'(popsSeen - base), 256'(1000));
        @(negedge clk);
        checkOutput("res_cnt_final", 256'(res_cnt), 256'(CNT_W'(popsSeen)));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
